// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the Pong game-state engine.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_X_L   = 16;
    localparam int DEF_PADDLE_X_R   = 616;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_AI_SPEED     = 3;
    localparam int DEF_PAUSE_FRAMES = 60;
    localparam int DEF_WIN_SCORE    = 9;

    // True when the ball's rows intersect the paddle's rows.
    function automatic logic y_overlap(input int ball_y, input int pad_y,
                                       input int ball_size, input int pad_h);
        return (ball_y + ball_size > pad_y) && (ball_y < pad_y + pad_h);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One vertically moving paddle; steps once per tick and saturates at the screen edges.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int SPEED    = DEF_PADDLE_SPEED,
    parameter int V_RES    = DEF_V_RES,
    parameter int PADDLE_H = DEF_PADDLE_H,
    parameter int Y_POS_W  = $clog2(V_RES)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tick_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [Y_POS_W-1:0] y
);

    localparam int Y_MAX = V_RES - PADDLE_H;
    localparam logic [Y_POS_W:0] STEP = (Y_POS_W+1)'(SPEED);
    localparam logic [Y_POS_W:0] TOP  = (Y_POS_W+1)'(Y_MAX);

    function automatic logic [Y_POS_W:0] sat_up(input logic [Y_POS_W:0] v);
        return (v < STEP) ? '0 : v - STEP;
    endfunction

    function automatic logic [Y_POS_W:0] sat_down(input logic [Y_POS_W:0] v);
        return (v + STEP > TOP) ? TOP : v + STEP;
    endfunction

    logic [Y_POS_W:0] y_ext;
    logic [Y_POS_W:0] y_next;

    always_comb begin
        y_ext  = {1'b0, y};
        y_next = y_ext;
        if (up_i && !down_i)
            y_next = sat_up(y_ext);
        else if (down_i && !up_i)
            y_next = sat_down(y_ext);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            y <= Y_POS_W'(Y_MAX / 2);
        else if (tick_i)
            y <= y_next[Y_POS_W-1:0];
    end

endmodule

// File: rtl/pong_engine.sv
// Per-frame Pong game state: ball, paddles, scores and round FSM, advanced on frame_tick_i.
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int X_POS_W      = $clog2(H_RES),
    parameter int Y_POS_W      = $clog2(V_RES),
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_X_L   = DEF_PADDLE_X_L,
    parameter int PADDLE_X_R   = DEF_PADDLE_X_R,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int AI_SPEED     = DEF_AI_SPEED,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               frame_tick_i,
    input  logic [1:0]         key_i,
    output logic [X_POS_W-1:0] ball_x_o,
    output logic [Y_POS_W-1:0] ball_y_o,
    output logic [Y_POS_W-1:0] paddle_l_y_o,
    output logic [Y_POS_W-1:0] paddle_r_y_o,
    output logic [3:0]         score_l_o,
    output logic [3:0]         score_r_o,
    output logic               game_over_o,
    output logic               led_o
);

    localparam int BALL_X0 = H_RES / 2 - BALL_SIZE / 2;
    localparam int BALL_Y0 = V_RES / 2 - BALL_SIZE / 2;
    localparam int FACE_L  = PADDLE_X_L + PADDLE_W;
    localparam int FACE_R  = PADDLE_X_R - BALL_SIZE;
    localparam int X_MAX   = H_RES - BALL_SIZE;
    localparam int Y_MAX   = V_RES - BALL_SIZE;
    localparam int CNT_W   = $clog2(PAUSE_FRAMES);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'(WIN_SCORE)) ? s : s + 4'd1;
    endfunction

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               dir_x, dir_x_n;   // 1 = right
    logic               dir_y, dir_y_n;   // 1 = down
    logic [X_POS_W-1:0] ball_x_n;
    logic [Y_POS_W-1:0] ball_y_n;
    logic [3:0]         score_l_n, score_r_n;
    logic [1:0]         key_p0, key_p1;
    logic               key_up, key_down, paddle_tick;
    logic               ai_up, ai_down, hit_l, hit_r;
    int                 bx, by, nx, ny, ball_c, pad_c;

    // Stage p0/p1: synchronise the raw active-low buttons.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_p0 <= 2'b11;
            key_p1 <= 2'b11;
        end else begin
            key_p0 <= key_i;
            key_p1 <= key_p0;
        end
    end

    assign key_up      = ~key_p1[0];
    assign key_down    = ~key_p1[1];
    assign paddle_tick = frame_tick_i && (state != OVER);

    always_comb begin
        ball_c  = int'(ball_y_o) + BALL_SIZE / 2;
        pad_c   = int'(paddle_r_y_o) + PADDLE_H / 2;
        ai_down = (ball_c - pad_c) > AI_SPEED;
        ai_up   = (pad_c - ball_c) > AI_SPEED;
    end

    pong_paddle #(
        .SPEED(PADDLE_SPEED), .V_RES(V_RES), .PADDLE_H(PADDLE_H), .Y_POS_W(Y_POS_W)
    ) u_paddle_l (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .tick_i(paddle_tick),
        .up_i(key_up), .down_i(key_down), .y(paddle_l_y_o)
    );

    pong_paddle #(
        .SPEED(AI_SPEED), .V_RES(V_RES), .PADDLE_H(PADDLE_H), .Y_POS_W(Y_POS_W)
    ) u_paddle_r (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .tick_i(paddle_tick),
        .up_i(ai_up), .down_i(ai_down), .y(paddle_r_y_o)
    );

    always_comb begin
        bx        = int'(ball_x_o);
        by        = int'(ball_y_o);
        nx        = bx;
        ny        = by;
        hit_l     = 1'b0;
        hit_r     = 1'b0;
        state_n   = state;
        cnt_n     = cnt;
        dir_x_n   = dir_x;
        dir_y_n   = dir_y;
        ball_x_n  = ball_x_o;
        ball_y_n  = ball_y_o;
        score_l_n = score_l_o;
        score_r_n = score_r_o;
        unique case (state)
            SERVE: begin
                ball_x_n = X_POS_W'(BALL_X0);
                ball_y_n = Y_POS_W'(BALL_Y0);
                if (cnt == CNT_W'(PAUSE_FRAMES - 1)) begin
                    cnt_n   = '0;
                    state_n = PLAY;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PLAY: begin
                nx = dir_x ? bx + BALL_SPEED : bx - BALL_SPEED;
                ny = dir_y ? by + BALL_SPEED : by - BALL_SPEED;
                if (!dir_y && by < BALL_SPEED) begin
                    ny      = 0;
                    dir_y_n = 1'b1;
                end else if (dir_y && by + BALL_SPEED >= Y_MAX) begin
                    ny      = Y_MAX;
                    dir_y_n = 1'b0;
                end
                hit_l = !dir_x && bx >= FACE_L && bx - BALL_SPEED <= FACE_L &&
                        y_overlap(by, int'(paddle_l_y_o), BALL_SIZE, PADDLE_H);
                hit_r = dir_x && bx <= FACE_R && bx + BALL_SPEED >= FACE_R &&
                        y_overlap(by, int'(paddle_r_y_o), BALL_SIZE, PADDLE_H);
                if (hit_l) begin
                    nx      = FACE_L;
                    dir_x_n = 1'b1;
                end else if (hit_r) begin
                    nx      = FACE_R;
                    dir_x_n = 1'b0;
                end
                // A miss freezes the ball exactly where it left the field.
                if (!hit_l && !hit_r && (bx < BALL_SPEED || bx + BALL_SPEED > X_MAX)) begin
                    state_n = MISS;
                    dir_y_n = dir_y;
                    if (bx < BALL_SPEED)
                        score_r_n = sat_inc(score_r_o);
                    else
                        score_l_n = sat_inc(score_l_o);
                end else begin
                    ball_x_n = X_POS_W'(nx);
                    ball_y_n = Y_POS_W'(ny);
                end
            end
            MISS: begin
                if (cnt == CNT_W'(PAUSE_FRAMES - 1)) begin
                    cnt_n = '0;
                    if (score_l_o == 4'(WIN_SCORE) || score_r_o == 4'(WIN_SCORE)) begin
                        state_n = OVER;
                    end else begin
                        state_n  = SERVE;
                        dir_x_n  = (bx >= H_RES / 2);
                        ball_x_n = X_POS_W'(BALL_X0);
                        ball_y_n = Y_POS_W'(BALL_Y0);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            OVER: begin
                if (key_up && key_down) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    ball_x_n  = X_POS_W'(BALL_X0);
                    ball_y_n  = Y_POS_W'(BALL_Y0);
                    state_n   = SERVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= SERVE;
            cnt       <= '0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            ball_x_o  <= X_POS_W'(BALL_X0);
            ball_y_o  <= Y_POS_W'(BALL_Y0);
            score_l_o <= '0;
            score_r_o <= '0;
        end else if (frame_tick_i) begin
            state     <= state_n;
            cnt       <= cnt_n;
            dir_x     <= dir_x_n;
            dir_y     <= dir_y_n;
            ball_x_o  <= ball_x_n;
            ball_y_o  <= ball_y_n;
            score_l_o <= score_l_n;
            score_r_o <= score_r_n;
        end
    end

    assign game_over_o = (state == OVER);
    assign led_o       = (state == MISS);

endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine: a frame-level game model predicts every tick's outputs.
`timescale 1ns/1ps
module tb_pong_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] key = 2'b11;
    logic [9:0] ball_x;
    logic [8:0] ball_y, paddle_l_y, paddle_r_y;
    logic [3:0] score_l, score_r;
    logic       game_over, led;

    pong_engine dut (
        .clk_i(clk), .rst_n_i(rst_n), .frame_tick_i(frame_tick), .key_i(key),
        .ball_x_o(ball_x), .ball_y_o(ball_y), .paddle_l_y_o(paddle_l_y),
        .paddle_r_y_o(paddle_r_y), .score_l_o(score_l), .score_r_o(score_r),
        .game_over_o(game_over), .led_o(led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int bx; int by; int pl; int pr; int sl; int sr; int over; int led;
    } snap_t;

    snap_t exp_q[$];
    int tests = 0;
    int fails = 0;

    localparam int S_SERVE = 0, S_PLAY = 1, S_MISS = 2, S_OVER = 3;
    int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
        m_st = S_SERVE; m_cnt = 0;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.bx = m_bx; s.by = m_by; s.pl = m_pl; s.pr = m_pr;
        s.sl = m_sl; s.sr = m_sr;
        s.over = (m_st == S_OVER) ? 1 : 0;
        s.led  = (m_st == S_MISS) ? 1 : 0;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.bx = int'(ball_x); s.by = int'(ball_y);
        s.pl = int'(paddle_l_y); s.pr = int'(paddle_r_y);
        s.sl = int'(score_l); s.sr = int'(score_r);
        s.over = int'(game_over); s.led = int'(led);
        return s;
    endfunction

    // One frame of game rules on the 640x480 field, using last frame's positions for collisions.
    task automatic model_tick(input bit up, input bit dn);
        int opl = m_pl;
        int opr = m_pr;
        int nx, ny, ndx, ndy;
        if (m_st != S_OVER) begin
            if (up && !dn)      m_pl = clamp(m_pl - 4, 0, 416);
            else if (dn && !up) m_pl = clamp(m_pl + 4, 0, 416);
            if ((m_by + 4) - (opr + 32) > 3)      m_pr = clamp(m_pr + 3, 0, 416);
            else if ((opr + 32) - (m_by + 4) > 3) m_pr = clamp(m_pr - 3, 0, 416);
        end
        case (m_st)
            S_SERVE: begin
                if (m_cnt == 59) begin m_cnt = 0; m_st = S_PLAY; end
                else m_cnt++;
            end
            S_PLAY: begin
                nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy; ndx = m_dx; ndy = m_dy;
                if (m_dy < 0 && m_by < 2) begin ny = 0; ndy = 1; end
                else if (m_dy > 0 && m_by + 2 >= 472) begin ny = 472; ndy = -1; end
                if (m_dx < 0 && m_bx >= 24 && m_bx - 2 <= 24 && m_by + 8 > opl && m_by < opl + 64) begin
                    nx = 24; ndx = 1;
                end else if (m_dx > 0 && m_bx <= 608 && m_bx + 2 >= 608 && m_by + 8 > opr && m_by < opr + 64) begin
                    nx = 608; ndx = -1;
                end else if (m_bx < 2) begin
                    m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_st = S_MISS;
                end else if (m_bx + 2 > 632) begin
                    m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_st = S_MISS;
                end
                if (m_st == S_PLAY) begin m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy; end
            end
            S_MISS: begin
                if (m_cnt == 59) begin
                    m_cnt = 0;
                    if (m_sl == 9 || m_sr == 9) m_st = S_OVER;
                    else begin
                        m_st = S_SERVE;
                        m_dx = (m_bx < 320) ? -1 : 1;
                        m_bx = 316; m_by = 236;
                    end
                end else m_cnt++;
            end
            default: begin
                if (up && dn) begin
                    m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_st = S_SERVE;
                end
            end
        endcase
    endtask

    task automatic check_snap(input string name, input snap_t e);
        snap_t a;
        a = dut_snap();
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got ball=(%0d,%0d) pad=(%0d,%0d) score=%0d:%0d over=%0d led=%0d, want ball=(%0d,%0d) pad=(%0d,%0d) score=%0d:%0d over=%0d led=%0d",
                     name, a.bx, a.by, a.pl, a.pr, a.sl, a.sr, a.over, a.led,
                     e.bx, e.by, e.pl, e.pr, e.sl, e.sr, e.over, e.led);
        end
    endtask

    // Keys settle through the synchroniser before the tick; expectation queued as the tick is issued.
    task automatic frame(input logic [1:0] k);
        key = k;
        repeat (3) @(negedge clk);
        model_tick(~k[0], ~k[1]);
        exp_q.push_back(model_snap());
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    function automatic logic [1:0] pick_keys(input bit track);
        int pc, bc;
        if (track) begin
            pc = m_pl + 32;
            bc = m_by + 4;
            if (pc > bc + 2)      return 2'b10;
            else if (pc < bc - 2) return 2'b01;
            else                  return 2'b11;
        end
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            if (frame_tick) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tick_without_expectation: got a tick, want a queued expectation");
                end else begin
                    e = exp_q.pop_front();
                    check_snap("tick", e);
                end
            end
        end
    end

    initial begin : driver
        bit track;
        int prev_dx, budget;
        logic [1:0] k;
        model_reset();
        repeat (3) @(negedge clk);
        check_snap("reset_values", model_snap());
        rst_n = 1'b1;

        repeat (61) frame(2'b11);
        repeat (60) frame(2'b10);
        repeat (5) frame(2'b00);

        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_snap("async_reset_mid_play", model_snap());
        repeat (2) @(negedge clk);
        key = 2'b11;
        rst_n = 1'b1;

        track = 1'b0;
        prev_dx = m_dx;
        budget = 18000;
        while (m_st != S_OVER && budget > 0) begin
            if ((m_dx < 0 && prev_dx > 0) || (m_st == S_SERVE && m_cnt == 0))
                track = ($urandom_range(0, 9) < 3);
            prev_dx = m_dx;
            frame(pick_keys(track));
            budget--;
        end
        @(negedge clk);
        tests++;
        if (game_over !== 1'b1) begin
            fails++;
            $display("FAIL game_over_reached: got game_over=%0d, want 1", game_over);
        end

        for (int i = 0; i < 6; i++) begin
            k = 2'($urandom_range(1, 3));
            frame(k);
        end
        frame(2'b00);
        repeat (3) frame(2'b11);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
